hnf_txrsp: RTL and testbench

- CHI link-layer transmitter for the HN-F TXRSP channel; the transmit-side counterpart of the HN-F RX channel receivers.
- Accepts response flits (Comp, CompDBIDResp, RetryAck, ...) from the HN-F pipeline over a valid/ready handshake and buffers them in a small FIFO.
- Sends flits on TXRSPFLIT only when holding an L-credit granted by the downstream RN via TXRSPLCRDV.
- Drives TXRSPFLITPEND one cycle ahead of TXRSPFLITV.

---
 rtl/chi_flit_pkg.sv | 35 +++
 rtl/chi_sync_fifo.sv | 49 ++++
 rtl/hnf_txrsp.sv | 75 +++++++
 tb/tb_hnf_txrsp.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/chi_flit_pkg.sv
// Shared CHI flit definitions for the HN-F link-layer transmitters and receivers.
`timescale 1ns/1ps
package chi_flit_pkg;

  // Architectural ceiling on L-credits a CHI receiver may hand out.
  localparam int CHI_MAX_LCRD = 15;

  typedef enum logic [3:0] {
    RSP_LCRD_RETURN    = 4'h0,
    RSP_SNP_RESP       = 4'h1,
    RSP_COMP_ACK       = 4'h2,
    RSP_RETRY_ACK      = 4'h3,
    RSP_COMP           = 4'h4,
    RSP_COMP_DBID_RESP = 4'h5,
    RSP_DBID_RESP      = 4'h6,
    RSP_PCRD_GRANT     = 4'h7,
    RSP_READ_RECEIPT   = 4'h8,
    RSP_SNP_RESP_FWDED = 4'h9
  } rsp_opcode_e;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgtid;
    logic [6:0]  srcid;
    logic [7:0]  txnid;
    rsp_opcode_e opcode;
    logic [1:0]  resperr;
    logic [2:0]  resp;
    logic [2:0]  fwdstate;
    logic [7:0]  dbid;
    logic [3:0]  pcrdtype;
    logic        tracetag;
  } rspflit_t;

endpackage

// File: rtl/chi_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; shared by the CHI TX channel transmitters.
`timescale 1ns/1ps
module chi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/hnf_txrsp.sv
// HN-F TXRSP link-layer transmitter: buffers response flits and sends them against L-credits.
`timescale 1ns/1ps
module hnf_txrsp
  import chi_flit_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_CRD = CHI_MAX_LCRD,
  localparam int CW     = $clog2(MAX_CRD + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  rspflit_t      txrspflit,
  input  logic          txrsp_valid,
  output logic          txrsp_ready,
  output rspflit_t      TXRSPFLIT,
  output logic          TXRSPFLITV,
  output logic          TXRSPFLITPEND,
  input  logic          TXRSPLCRDV,
  output logic [CW-1:0] crd_cnt,
  output logic          txrsp_idle,
  output logic          crd_overflow
);

  localparam logic [CW-1:0] CRD_MAX = CW'(MAX_CRD);

  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic [$bits(rspflit_t)-1:0] head_bits;
  logic                      launch;

  chi_sync_fifo #(
    .WIDTH ($bits(rspflit_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (txrsp_valid),
    .push_data (txrspflit),
    .pop       (launch),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign launch = !fifo_empty && (crd_cnt != '0);

  // Reset forces the handshake-facing outputs to their idle values before the first edge lands.
  assign txrsp_ready   = reset || !fifo_full;
  assign TXRSPFLITPEND = launch && !reset;
  assign txrsp_idle    = reset || ((fifo_count == '0) && !TXRSPFLITV);

  always_ff @(posedge clock) begin
    if (reset) begin
      TXRSPFLITV   <= 1'b0;
      TXRSPFLIT    <= '0;
      crd_cnt      <= '0;
      crd_overflow <= 1'b0;
    end else begin
      TXRSPFLITV <= launch;
      TXRSPFLIT  <= launch ? rspflit_t'(head_bits) : '0;
      // A grant coinciding with a launch nets to zero; a surplus grant at the ceiling is dropped and flagged.
      case ({launch, TXRSPLCRDV})
        2'b10: crd_cnt <= crd_cnt - 1'b1;
        2'b01: begin
          if (crd_cnt == CRD_MAX) crd_overflow <= 1'b1;
          else                    crd_cnt      <= crd_cnt + 1'b1;
        end
        default: crd_cnt <= crd_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_hnf_txrsp.sv
// Scoreboard bench for hnf_txrsp: directed pushes and credit grants, monitor checks link flits in order.
`timescale 1ns/1ps
module tb_hnf_txrsp;
  import chi_flit_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_CRD = CHI_MAX_LCRD;
  localparam int CW      = $clog2(MAX_CRD + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  rspflit_t      txrspflit;
  logic          txrsp_valid = 1'b0;
  logic          txrsp_ready;
  rspflit_t      TXRSPFLIT;
  logic          TXRSPFLITV;
  logic          TXRSPFLITPEND;
  logic          TXRSPLCRDV = 1'b0;
  logic [CW-1:0] crd_cnt;
  logic          txrsp_idle;
  logic          crd_overflow;

  int       checkCount = 0;
  int       errorCount = 0;
  rspflit_t expQ[$];
  rspflit_t expFlit;
  int       beatCount = 0;
  int       curRun = 0;
  int       maxRun = 0;

  always #5 clock = ~clock;

  hnf_txrsp #(
    .DEPTH   (DEPTH),
    .MAX_CRD (MAX_CRD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .txrspflit     (txrspflit),
    .txrsp_valid   (txrsp_valid),
    .txrsp_ready   (txrsp_ready),
    .TXRSPFLIT     (TXRSPFLIT),
    .TXRSPFLITV    (TXRSPFLITV),
    .TXRSPFLITPEND (TXRSPFLITPEND),
    .TXRSPLCRDV    (TXRSPLCRDV),
    .crd_cnt       (crd_cnt),
    .txrsp_idle    (txrsp_idle),
    .crd_overflow  (crd_overflow)
  );

  function automatic rspflit_t makeFlit(input logic [7:0] txnid);
    rspflit_t f;
    f          = '0;
    f.qos      = 4'h3;
    f.tgtid    = 7'h12;
    f.srcid    = 7'h05;
    f.txnid    = txnid;
    f.opcode   = txnid[0] ? RSP_COMP : RSP_COMP_DBID_RESP;
    f.resp     = txnid[2:0];
    f.dbid     = txnid ^ 8'hA5;
    return f;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; an accepted push is recorded on the scoreboard.
  task automatic applyStimulus(input logic valid, input logic [7:0] txnid, input logic lcrdv);
    txrsp_valid = valid;
    txrspflit   = valid ? makeFlit(txnid) : '0;
    TXRSPLCRDV  = lcrdv;
    if (valid) expQ.push_back(makeFlit(txnid));
    tick();
    txrsp_valid = 1'b0;
    txrspflit   = '0;
    TXRSPLCRDV  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every link beat must match the oldest outstanding push.
  always @(negedge clock) begin
    if (TXRSPFLITV === 1'b1) begin
      beatCount++;
      curRun++;
      if (curRun > maxRun) maxRun = curRun;
      checkCount++;
      if (expQ.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL unexpected_flit: got txnid %0h, expected no flit", TXRSPFLIT.txnid);
      end else begin
        expFlit = expQ.pop_front();
        if (TXRSPFLIT !== expFlit) begin
          errorCount++;
          $display("[TB] FAIL link_flit: got %h, expected %h", TXRSPFLIT, expFlit);
        end
      end
    end else begin
      curRun = 0;
    end
    if (reset) expQ.delete();
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txrspflit = '0;

    #1;
    checkOutput("reset_ready", txrsp_ready, 1);
    checkOutput("reset_pend", TXRSPFLITPEND, 0);
    checkOutput("reset_idle", txrsp_idle, 1);
    tick();
    tick();
    checkOutput("reset_crd", crd_cnt, 0);
    checkOutput("reset_flitv", TXRSPFLITV, 0);
    checkOutput("reset_flit", TXRSPFLIT, 0);
    checkOutput("reset_overflow", crd_overflow, 0);
    reset = 1'b0;

    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("nocrd_ready_3", txrsp_ready, 1);
    checkOutput("nocrd_flitv", TXRSPFLITV, 0);
    checkOutput("nocrd_pend", TXRSPFLITPEND, 0);
    checkOutput("nocrd_crd", crd_cnt, 0);
    applyStimulus(1'b1, 8'd4, 1'b0);
    checkOutput("nocrd_ready_4", txrsp_ready, 0);

    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("one_crd_cnt", crd_cnt, 1);
    checkOutput("one_crd_pend", TXRSPFLITPEND, 1);
    checkOutput("one_crd_flitv0", TXRSPFLITV, 0);
    tick();
    checkOutput("one_crd_flitv1", TXRSPFLITV, 1);
    checkOutput("one_crd_txnid", TXRSPFLIT.txnid, 1);
    checkOutput("one_crd_spent", crd_cnt, 0);
    checkOutput("one_crd_pend0", TXRSPFLITPEND, 0);
    checkOutput("one_crd_ready", txrsp_ready, 1);

    doReset();
    checkOutput("rst2_idle", txrsp_idle, 1);
    checkOutput("rst2_crd", crd_cnt, 0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("grant15_crd", crd_cnt, 15);
    checkOutput("grant15_ovf", crd_overflow, 0);
    beatCount = 0;
    curRun    = 0;
    maxRun    = 0;
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    repeat (4) tick();
    checkOutput("stream_beats", beatCount, 6);
    checkOutput("stream_run", maxRun, 6);
    checkOutput("stream_crd", crd_cnt, 9);
    checkOutput("stream_idle", txrsp_idle, 1);
    checkOutput("stream_drained", expQ.size(), 0);

    doReset();
    applyStimulus(1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("hold_start", crd_cnt, 2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 5, 8'(20 + i), i >= 1);
      checkOutput($sformatf("hold_crd_%0d", i), crd_cnt, 2);
    end
    tick();
    checkOutput("hold_end_crd", crd_cnt, 2);
    checkOutput("hold_end_idle", txrsp_idle, 1);

    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("sat_crd15", crd_cnt, 15);
    checkOutput("sat_ovf0", crd_overflow, 0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("sat_crd_hold", crd_cnt, 15);
    checkOutput("sat_ovf1", crd_overflow, 1);
    repeat (3) tick();
    checkOutput("sat_ovf_sticky", crd_overflow, 1);
    applyStimulus(1'b1, 8'h40, 1'b0);
    tick();
    checkOutput("sat_launch_crd", crd_cnt, 14);
    checkOutput("sat_launch_flitv", TXRSPFLITV, 1);
    checkOutput("sat_launch_ovf", crd_overflow, 1);

    doReset();
    checkOutput("rst_clears_ovf", crd_overflow, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0);
    checkOutput("midrst_full", txrsp_ready, 0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("midrst_crd1", crd_cnt, 1);
    checkOutput("midrst_pend", TXRSPFLITPEND, 1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("midrst_flitv", TXRSPFLITV, 1);
    checkOutput("midrst_crd_net", crd_cnt, 1);
    reset = 1'b1;
    tick();
    checkOutput("midrst_flitv0", TXRSPFLITV, 0);
    checkOutput("midrst_crd0", crd_cnt, 0);
    checkOutput("midrst_idle", txrsp_idle, 1);
    checkOutput("midrst_ready", txrsp_ready, 1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("post_rst_flitv_%0d", i), TXRSPFLITV, 0);
      checkOutput($sformatf("post_rst_pend_%0d", i), TXRSPFLITPEND, 0);
    end
    checkOutput("post_rst_queue", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
